// File: rtl/data_packer_pkg.sv
// data_packer_pkg: shared widths and sizing helpers for the packer/unpacker pair.
`ifndef C_LOG_2
`define C_LOG_2(n) ($clog2(n))
`endif

package data_packer_pkg;
   localparam int DEF_NARROW_WIDTH = 64;
   localparam int DEF_WIDE_WIDTH   = 128;

   function automatic int ceil_a_by_b(input int a, input int b);
      return (a + b - 1) / b;
   endfunction
endpackage

// File: rtl/data_packer_slot.sv
// data_packer_slot: output holding register for one wide word.
// Loads on i_load and emits a one-cycle strobe when the receiver is ready.
module data_packer_slot #(
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_rdy,
   output logic             o_full,
   output logic             o_en,
   output logic [WIDTH-1:0] o_data
);
   logic             r_full;
   logic [WIDTH-1:0] r_data;
   logic             w_en;

   assign w_en   = r_full & i_rdy;
   assign o_full = r_full;
   assign o_en   = w_en;
   assign o_data = r_data;

   // Hold the word until the receiver takes it; the owner only loads when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else begin
         if (i_load) r_data <= i_data;
         r_full <= i_load | (r_full & ~w_en);
      end
   end
endmodule

// File: rtl/data_packer.sv
// data_packer: gathers NARROW_WIDTH words into WIDE_WIDTH words (first word in LSBs)
// with an assembly register plus one output slot.
// Optional: define DATA_PACKER_OVF_CHK_EN to add the Ovf / Drop_Cnt dropped-write monitor.
module data_packer
   import data_packer_pkg::*;
#(
   parameter int NARROW_WIDTH = DEF_NARROW_WIDTH,
   parameter int WIDE_WIDTH   = DEF_WIDE_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    Unpacked_EnWr,
   input  logic [NARROW_WIDTH-1:0] Unpacked_DatWr,
   output logic                    Unpacked_RdyWr,
   input  logic                    Flush,
   input  logic                    Packed_RdyWr,
   output logic                    Packed_EnWr,
   output logic [WIDE_WIDTH-1:0]   Packed_DatWr
`ifdef DATA_PACKER_OVF_CHK_EN
   ,
   output logic                    Ovf,
   output logic [15:0]             Drop_Cnt
`endif
);
   localparam int WORDS_RAW = ceil_a_by_b(WIDE_WIDTH, NARROW_WIDTH);
   localparam int WORDS     = (WORDS_RAW < 1) ? 1 : WORDS_RAW;
   localparam int CW        = `C_LOG_2(WORDS + 1);
   localparam int AW        = WORDS * NARROW_WIDTH;
   localparam logic [CW-1:0] C_WORDS = CW'(WORDS);

   logic [AW-1:0] r_asm_data;
   logic [CW-1:0] r_asm_cnt;
   logic          r_flush_pend;

   logic          w_asm_full;
   logic          w_out_full;
   logic          w_rdy;
   logic          w_acc;
   logic          w_xfer;
   logic [CW-1:0] w_cnt_base;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_flush_set;
   logic [AW-1:0] w_asm_nxt;

   assign w_asm_full     = (r_asm_cnt == C_WORDS) | r_flush_pend;
   assign w_rdy          = ~w_asm_full | ~w_out_full;
   assign w_acc          = Unpacked_EnWr & w_rdy;
   assign w_xfer         = w_asm_full & ~w_out_full;
   assign Unpacked_RdyWr = w_rdy;

   // Next assembly: a transfer empties it first, then an accepted word lands in the
   // current lane; a flush closes it only if the result is partial and non-empty.
   always_comb begin
      w_cnt_base  = w_xfer ? '0 : r_asm_cnt;
      w_cnt_nxt   = w_cnt_base + CW'(w_acc);
      w_flush_set = Flush && (w_cnt_nxt != '0) && (w_cnt_nxt < C_WORDS);
      w_asm_nxt   = w_xfer ? '0 : r_asm_data;
      if (w_acc)
         w_asm_nxt[int'(w_cnt_base)*NARROW_WIDTH +: NARROW_WIDTH] = Unpacked_DatWr;
   end

   // Assembly register, lane counter and pending-flush flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_asm_data   <= '0;
         r_asm_cnt    <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         r_asm_data   <= w_asm_nxt;
         r_asm_cnt    <= w_cnt_nxt;
         r_flush_pend <= w_xfer ? w_flush_set : (r_flush_pend | w_flush_set);
      end
   end

   data_packer_slot #(.WIDTH(WIDE_WIDTH)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_xfer),
      .i_data (r_asm_data[WIDE_WIDTH-1:0]),
      .i_rdy  (Packed_RdyWr),
      .o_full (w_out_full),
      .o_en   (Packed_EnWr),
      .o_data (Packed_DatWr)
   );

`ifdef DATA_PACKER_OVF_CHK_EN
   logic        r_ovf;
   logic [15:0] r_drop_cnt;
   logic        w_drop;

   assign w_drop   = Unpacked_EnWr & ~w_rdy;
   assign Ovf      = r_ovf;
   assign Drop_Cnt = r_drop_cnt;

   // Sticky overflow flag and saturating count of refused writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf      <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
         if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_data_packer.sv
// tb_data_packer: randomized and directed checks of data_packer against a queue-based model.
module tb_data_packer;
   localparam int WORDS = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         en, fl, prdy;
   logic [63:0]  din;
   logic         rdy_o, pen;
   logic [127:0] pdat;

   logic         en2;
   logic [47:0]  d2;
   logic         rdy2, pen2;
   logic [127:0] pdat2;

`ifdef DATA_PACKER_OVF_CHK_EN
   logic         ovf, ovf2;
   logic [15:0]  dcnt, dcnt2;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   data_packer #(.NARROW_WIDTH(64), .WIDE_WIDTH(128)) dut (
      .clk(clk), .rst(rst),
      .Unpacked_EnWr(en), .Unpacked_DatWr(din), .Unpacked_RdyWr(rdy_o),
      .Flush(fl), .Packed_RdyWr(prdy), .Packed_EnWr(pen), .Packed_DatWr(pdat)
`ifdef DATA_PACKER_OVF_CHK_EN
      , .Ovf(ovf), .Drop_Cnt(dcnt)
`endif
   );

   data_packer #(.NARROW_WIDTH(48), .WIDE_WIDTH(128)) dut2 (
      .clk(clk), .rst(rst),
      .Unpacked_EnWr(en2), .Unpacked_DatWr(d2), .Unpacked_RdyWr(rdy2),
      .Flush(1'b0), .Packed_RdyWr(1'b1), .Packed_EnWr(pen2), .Packed_DatWr(pdat2)
`ifdef DATA_PACKER_OVF_CHK_EN
      , .Ovf(ovf2), .Drop_Cnt(dcnt2)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: queued narrow words, a "closed by flush" flag, one pending wide word.
   logic [63:0]  m_asm[$];
   bit           m_closed;
   bit           m_out_full;
   logic [127:0] m_out;
   logic [127:0] emq[$];

   function automatic bit m_full();
      return (m_asm.size() == WORDS) || m_closed;
   endfunction

   function automatic logic [127:0] m_pack();
      logic [127:0] w = '0;
      foreach (m_asm[i]) w = w | (128'(m_asm[i]) << (i * 64));
      return w;
   endfunction

   task automatic m_clear();
      m_asm.delete();
      m_closed   = 0;
      m_out_full = 0;
      m_out      = '0;
   endtask

   // One cycle: drive, compare against the model, then advance the model past the edge.
   task automatic step(input logic e, input logic [63:0] d, input logic f, input logic p,
                       output bit accd);
      bit r, emit, xfer;
      @(negedge clk);
      en = e; din = d; fl = f; prdy = p;
      #1;
      r    = !m_full() || !m_out_full;
      emit = m_out_full && p;
      xfer = m_full() && !m_out_full;
      chk("rdy", rdy_o, r);
      chk("en", pen, emit);
      if (emit) chk("dat", pdat, m_out);
      if (pen) emq.push_back(pdat);
      accd = e && rdy_o;
      if (emit) m_out_full = 0;
      if (xfer) begin
         m_out      = m_pack();
         m_out_full = 1;
         m_asm.delete();
         m_closed   = 0;
      end
      if (e && r) m_asm.push_back(d);
      if (f && m_asm.size() > 0 && m_asm.size() < WORDS) m_closed = 1;
   endtask

   task automatic idle(input int n, input logic p);
      bit a;
      for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b0, p, a);
   endtask

   task automatic wr(input logic [63:0] d, input logic p);
      bit a;
      a = 0;
      for (int k = 0; k < 20 && !a; k++) step(1'b1, d, 1'b0, p, a);
      if (!a) chk("wr_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; en = 0; fl = 0; prdy = 1; en2 = 0;
      #1;
      chk("rst_rdy", rdy_o, 1);
      chk("rst_en", pen, 0);
      chk("rst_dat", pdat, 0);
      @(negedge clk);
      #1;
      chk("rst_hold_en", pen, 0);
      rst = 0;
      m_clear();
   endtask

   initial begin
      bit           a;
      int           n;
      logic [127:0] got2;
      bit           seen2;
      rst = 1; en = 0; fl = 0; prdy = 0; din = '0; en2 = 0; d2 = '0;
      m_clear();
      repeat (2) @(negedge clk);
      rst = 0;

      // reset mid-assembly discards the partial word
      step(1'b1, 64'h1111_1111_1111_1111, 1'b0, 1'b1, a);
      do_reset();
      emq.delete();
      idle(5, 1'b1);
      chk("rst_no_stale", emq.size(), 0);

      // basic pair
      emq.delete();
      step(1'b1, 64'h1111_1111_1111_1111, 1'b0, 1'b1, a);
      step(1'b1, 64'h2222_2222_2222_2222, 1'b0, 1'b1, a);
      idle(3, 1'b1);
      chk("basic_n", emq.size(), 1);
      if (emq.size() > 0)
         chk("basic_dat", emq[0], 128'h2222_2222_2222_2222_1111_1111_1111_1111);

      // backpressure: four words fit, then ready drops
      emq.delete();
      n = 0;
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, 64'(i), 1'b0, 1'b0, a);
         n += int'(a);
      end
      chk("bp_acc", n, 4);
      chk("bp_rdy_low", rdy_o, 0);
      wr(64'd5, 1'b1);
      wr(64'd6, 1'b1);
      step(1'b0, 64'h0, 1'b1, 1'b1, a);
      idle(6, 1'b1);
      chk("bp_n", emq.size(), 3);
      if (emq.size() == 3) begin
         chk("bp_w0", emq[0], {64'd2, 64'd1});
         chk("bp_w1", emq[1], {64'd4, 64'd3});
         chk("bp_w2", emq[2], {64'd6, 64'd5});
      end

      // flush of a partial word
      emq.delete();
      step(1'b1, 64'hABCD, 1'b0, 1'b1, a);
      step(1'b0, 64'h0, 1'b1, 1'b1, a);
      idle(4, 1'b1);
      chk("fl_n", emq.size(), 1);
      if (emq.size() > 0) chk("fl_dat", emq[0], 128'hABCD);

      // flush with empty assembly
      emq.delete();
      step(1'b0, 64'h0, 1'b1, 1'b1, a);
      idle(4, 1'b1);
      chk("fl_empty_n", emq.size(), 0);

      // flush coincident with the filling write
      emq.delete();
      step(1'b1, 64'hC1, 1'b0, 1'b1, a);
      step(1'b1, 64'hC2, 1'b1, 1'b1, a);
      idle(5, 1'b1);
      chk("fl_co_n", emq.size(), 1);
      if (emq.size() > 0) chk("fl_co_dat", emq[0], {64'hC2, 64'hC1});

      // flush coincident with the first write of a word
      emq.delete();
      step(1'b1, 64'hD1, 1'b1, 1'b1, a);
      idle(4, 1'b1);
      chk("fl_first_n", emq.size(), 1);
      if (emq.size() > 0) chk("fl_first_dat", emq[0], 128'hD1);

      // randomized traffic
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) < 6, a);
      step(1'b0, 64'h0, 1'b1, 1'b1, a);
      idle(6, 1'b1);

      // uneven widths: 48-bit lanes, top of the third lane dropped
      seen2 = 0;
      got2  = '0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         en2 = 1;
         d2  = {12{4'(i)}};
      end
      @(negedge clk);
      en2 = 0;
      for (int k = 0; k < 10 && !seen2; k++) begin
         #1;
         if (pen2) begin
            seen2 = 1;
            got2  = pdat2;
         end
         @(negedge clk);
      end
      chk("uneven_seen", seen2, 1);
      chk("uneven_dat", got2, {32'h3333_3333, 48'h2222_2222_2222, 48'h1111_1111_1111});

`ifdef DATA_PACKER_OVF_CHK_EN
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 64'(i), 1'b0, 1'b0, a);
      for (int i = 0; i < 3; i++) step(1'b1, 64'hEE, 1'b0, 1'b0, a);
      step(1'b0, 64'h0, 1'b0, 1'b0, a);
      chk("ovf", ovf, 1);
      chk("drop_cnt", dcnt, 3);
      idle(4, 1'b0);
      chk("ovf_hold", ovf, 1);
      chk("drop_hold", dcnt, 3);
      do_reset();
      chk("ovf_rst", ovf, 0);
      chk("drop_rst", dcnt, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/data_packer.md
# data_packer

Narrow-to-wide word packer: gathers `NARROW_WIDTH`-bit words from an upstream producer into `WIDE_WIDTH`-bit words and hands each completed wide word to a downstream `unpacker`-style receiver over the strobe/level-ready write handshake. It sits at the write end of every packed link; its `Packed_*` port group connects directly to the receiver's `Packed_RdyWr` / `Packed_EnWr` / `Packed_DatWr`. It has a two-slot structure (assembly register + output slot), so one wide word can wait on backpressure while the next one is being assembled.

## Interface
- `NARROW_WIDTH`, 64: upstream word width.
- `WIDE_WIDTH`, 128: packed word width.
- `WORDS` (localparam): ceil(`WIDE_WIDTH`/`NARROW_WIDTH`), minimum 1. Lane counter width is `C_LOG_2(WORDS+1)`.
- `clk`  in  1  clock. One clock domain; every register is on `posedge clk`.
- `rst`  in  1  reset, asynchronous, active-high.
- `Unpacked_EnWr`  in  1  upstream write strobe.
- `Unpacked_DatWr`  in  `NARROW_WIDTH`  upstream data.
- `Unpacked_RdyWr`  out  1  upstream may write this cycle.
- `Flush`  in  1  close the partial wide word, zero-padded.
- `Packed_RdyWr`  in  1  level ready from the downstream receiver.
- `Packed_EnWr`  out  1  one-cycle write strobe to the receiver.
- `Packed_DatWr`  out  `WIDE_WIDTH`  packed data, valid while `Packed_EnWr` is high.

## Operation
- State:
  - `asm_data`: `WORDS*NARROW_WIDTH` bits.
  - `asm_cnt`: 0..`WORDS`.
  - `asm_full` = (`asm_cnt` == `WORDS`) or a flush is pending.
  - `out_data`, `out_full`.
- Write acceptance: `acc` = `Unpacked_EnWr` & `Unpacked_RdyWr`.
  - An accepted word goes into lane `asm_cnt`, bits [`asm_cnt*NARROW_WIDTH` +: `NARROW_WIDTH`], and `asm_cnt` increments.
  - The first word lands in the LSBs, matching the right-shift order of the receiver.
- `Unpacked_RdyWr` = !`asm_full` | !`out_full`. It is built from registered state only; there is no combinational path from `Packed_RdyWr`.
- Transfer, `xfer` = `asm_full` & !`out_full`:
  - `out_data` <= `asm_data[WIDE_WIDTH-1:0]` (lane bits above `WIDE_WIDTH` are dropped).
  - `asm_data` <= 0, `asm_cnt` <= 0.
  - A write accepted in the same cycle lands in lane 0 of the new assembly, with `asm_cnt` <= 1.
- Emission: `Packed_EnWr` = `out_full` & `Packed_RdyWr`, and `Packed_DatWr` = `out_data`.
  - `out_full` next = `xfer` | (`out_full` & !`Packed_EnWr`).
  - Emission and `xfer` in the same cycle are not allowed: `xfer` needs !`out_full`. This costs one bubble per word under continuous backpressure release, which is acceptable because the receiver drops ready for ≥1 cycle after every load.
- Flush:
  - `Flush` with 0 < `asm_cnt` < `WORDS` marks the assembly full. Unwritten lanes are already zero.
  - `Flush` with `asm_cnt` == 0 is a no-op.
  - `Flush` together with an accepted write: the write lands first, then the flush applies. If that write fills the last lane, the word is a normal full word and there is no extra output.
- A write while `Unpacked_RdyWr` is low is ignored.

## Timing
- During and after reset all outputs are 0, except `Unpacked_RdyWr` = 1.
  - Register reset values: `asm_cnt`=0, `asm_data`=0, `out_data`=0, `out_full`=0.
  - Reset asserted mid-assembly discards all partial and pending data immediately.
- Latency: last lane accepted at cycle t → `xfer` at t+1 → `out_full` at t+2 → `Packed_EnWr` at t+2 if `Packed_RdyWr` is high, otherwise on the first later cycle it is high.
- Capacity: one wide word in the output slot plus `WORDS` lanes in the assembly register.
- Back-to-back writes with an idle downstream never see `Unpacked_RdyWr` low.

## Configuration
- `DATA_PACKER_OVF_CHK_EN` defined:
  - Adds output `Ovf` (1 bit, sticky, reset 0). It is set when `Unpacked_EnWr` is high while `Unpacked_RdyWr` is low.
  - Adds output `Drop_Cnt` (16 bits, saturating) counting those cycles.
- Undefined: neither port exists. A dropped write is silently ignored.

## Structure
- Shared parameter header/package holds:
  - the `C_LOG_2` macro;
  - the ceil_a_by_b function;
  - the default narrow/wide widths shared with `unpacker`.
- One sub-module: `data_packer_slot`, the output holding register with its full flag and the load/emit handshake. The top level holds the lane assembly, counter and flush logic.

## Test plan
All scenarios use `NARROW_WIDTH`=64 and `WIDE_WIDTH`=128 unless stated.
- Reset: assert `rst` mid-assembly after one word → all outputs 0, `Unpacked_RdyWr`=1; no stale data emitted after release.
- Basic: write A=0x1111_1111_1111_1111 at cycle 0 and B=0x2222_2222_2222_2222 at cycle 1, with `Packed_RdyWr`=1 → a single `Packed_EnWr` pulse at cycle 3 with `Packed_DatWr`=0x2222…2222_1111…1111.
- Backpressure: `Packed_RdyWr`=0, attempt 6 writes (1..6) → 4 accepted, then `Unpacked_RdyWr`=0. Raise ready → {2,1} then {4,3} emitted in order; writes 5 and 6 are accepted once ready returns.
- Flush: write C=0xABCD, then pulse `Flush` → `Packed_DatWr`=0x0…0_0000…ABCD. Flush with an empty assembly → no `Packed_EnWr`. Flush coincident with the second write → exactly one full word.
- Uneven widths (`NARROW_WIDTH`=48, `WIDE_WIDTH`=128, `WORDS`=3): write 0x111…, 0x222…, 0x333… (48-bit each) → `Packed_DatWr` = {0x333…[31:0], 0x222…, 0x111…}, top 16 bits of the third word dropped.
- With `DATA_PACKER_OVF_CHK_EN`: drive `Unpacked_EnWr` for 3 cycles while `Unpacked_RdyWr`=0 → `Ovf`=1 and `Drop_Cnt`=3. Both remain until `rst`.
